// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default baud divisor and
// frame-length helper. Used by the transmitter and the future receiver.
package uart_pkg;

  // Frame states, shared with the receiver.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_t;

  // 100 MHz system clock, 115200 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  // Total clk cycles on the line for one frame, start bit through last stop bit.
  function automatic int frame_cycles(input int data_bits,
                                      input int parity_en,
                                      input int stop_bits,
                                      input int clks_per_bit);
    return (1 + data_bits + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Per-bit baud timer. Counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// count of each bit. clear forces the count back to 0 so every state starts
// on a fresh bit period; the count never wraps mid-bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Bit-period counter; restarts on clear or at the bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || (count == LAST_CNT)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST_CNT);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serialiser. Pops one byte from the transmit FIFO when it is
// non-empty and enable is set, then drives start, data (LSB first), optional
// parity and stop bits onto tx. Sole driver of the tx pin.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line high; pop the FIFO when enabled and non-empty
// LOAD   | one cycle waiting for FIFO data; capture byte and parity
// START  | start bit (tx=0) for one bit period
// DATA   | data bits LSB first, shift right at each bit boundary
// PARITY | captured parity bit for one bit period
// STOP   | stop bit(s) high; tx_done in the final cycle
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  // Wide enough to index up to 9 data bits and 2 stop bits.
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_SENSE = (PARITY_ODD != 0);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  uart_state_t          state;
  uart_state_t          state_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_next;
  logic                 parity_bit;
  logic                 parity_next;
  logic                 tick;
  logic                 baud_clear;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  // Restart the bit period on every state entry; hold it at zero while idle.
  assign baud_clear = (state == IDLE) || (state_next != state);

  assign busy = (state != IDLE);

  // State and datapath registers; reset drops any byte in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_idx    <= bit_idx_next;
      parity_bit <= parity_next;
    end
  end

  // Next-state, datapath update and line/handshake outputs.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx;
    parity_next  = parity_bit;
    fifo_rd_en   = 1'b0;
    tx           = 1'b1;
    tx_done      = 1'b0;

    case (state)
      IDLE: begin
        // Gating with reset keeps the pop request low while reset is held,
        // since the state register sits in IDLE during reset.
        if (enable && !fifo_empty && reset) begin
          fifo_rd_en = 1'b1;
          state_next = LOAD;
        end
      end

      LOAD: begin
        shift_next   = fifo_rd_data;
        parity_next  = (^fifo_rd_data) ^ PAR_SENSE;
        bit_idx_next = '0;
        state_next   = START;
      end

      START: begin
        tx = 1'b0;
        if (tick) begin
          state_next = DATA;
        end
      end

      DATA: begin
        tx = shift_reg[0];
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_idx == LAST_DATA) begin
            bit_idx_next = '0;
            state_next   = HAS_PAR ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
          end
        end
      end

      PARITY: begin
        tx = parity_bit;
        if (tick) begin
          state_next = STOP;
        end
      end

      STOP: begin
        tx = 1'b1;
        if (tick) begin
          if (bit_idx == LAST_STOP) begin
            tx_done      = 1'b1;
            bit_idx_next = '0;
            state_next   = IDLE;
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
